// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg
//   Shared constants for the four-digit display scanner: connector pin
//   numbers for digit selects and segments, default scan timing, the
//   handshake state enum, and a helper that places digit/segment values
//   onto the 12-pin connector vector.
package seven_segment_pkg;

   localparam int DEF_DIGIT_CYCLES = 50000;
   localparam int DEF_BLANK_CYCLES = 16;

   // Digit selects (active-low)
   localparam int DIG0_PIN = 12;
   localparam int DIG1_PIN = 9;
   localparam int DIG2_PIN = 8;
   localparam int DIG3_PIN = 6;

   // Segments (active-high)
   localparam int SEG_A_PIN  = 11;
   localparam int SEG_B_PIN  = 7;
   localparam int SEG_C_PIN  = 4;
   localparam int SEG_D_PIN  = 2;
   localparam int SEG_E_PIN  = 1;
   localparam int SEG_F_PIN  = 10;
   localparam int SEG_G_PIN  = 5;
   localparam int SEG_DP_PIN = 3;

   typedef enum logic {IDLE, WAIT_LOW} hs_state_t;

   // dig_n[i] drives digit i select; seg is {a,b,c,d,e,f,g,dp}.
   function automatic logic [1:12] pin_map(logic [3:0] dig_n, logic [7:0] seg);
      logic [1:12] p;
      p             = '0;
      p[DIG0_PIN]   = dig_n[0];
      p[DIG1_PIN]   = dig_n[1];
      p[DIG2_PIN]   = dig_n[2];
      p[DIG3_PIN]   = dig_n[3];
      p[SEG_A_PIN]  = seg[7];
      p[SEG_B_PIN]  = seg[6];
      p[SEG_C_PIN]  = seg[5];
      p[SEG_D_PIN]  = seg[4];
      p[SEG_E_PIN]  = seg[3];
      p[SEG_F_PIN]  = seg[2];
      p[SEG_G_PIN]  = seg[1];
      p[SEG_DP_PIN] = seg[0];
      return p;
   endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// seven_segment_scanner_if
//   MCU write port of the display scanner: four-phase strobe/ack handshake.
//   wr_strobe : write request (asynchronous to the scanner clock)
//   wr_addr   : digit index 0..3
//   wr_data   : segment pattern {a,b,c,d,e,f,g,dp}, 1 = lit
//   wr_ack    : acknowledge back to the MCU
interface seven_segment_scanner_if;
   logic       wr_strobe;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ack;

   modport master (output wr_strobe, output wr_addr, output wr_data, input wr_ack);
   modport slave  (input wr_strobe, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
//   Generic 1-bit two-flop synchronizer with synchronous active-high reset.
//   clock : destination clock
//   reset : synchronous reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (second flop)
module sync_2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Stores four segment patterns written by the MCU over a strobe/ack
//   handshake and time-multiplexes them onto a 12-pin display connector,
//   blanking all digits for BLANK_CYCLES at the start of each slot.
//   clock   : system clock
//   reset   : synchronous, active-high
//   bus     : MCU write port (slave side)
//   display : connector pins [1:12], registered
module seven_segment_scanner
   import seven_segment_pkg::*;
#(
   parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic                    clock,
   input  logic                    reset,
   seven_segment_scanner_if.slave  bus,
   output logic [1:12]             display
);

   localparam int CNT_W = $clog2(DIGIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   logic            strobe_s;
   hs_state_t       state_q, state_d;
   logic            wr_en;
   logic [3:0][7:0] pattern;
   logic [CNT_W-1:0] cycle_cnt;
   logic [1:0]      digit_idx;
   logic [3:0]      dig_n;
   logic [7:0]      seg;

   sync_2ff u_strobe_sync (
      .clock (clock),
      .reset (reset),
      .d     (bus.wr_strobe),
      .q     (strobe_s)
   );

   // Handshake FSM: one write per strobe pulse; address/data are sampled
   // only on the IDLE->WAIT_LOW transition.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (strobe_s) begin
               wr_en   = 1'b1;
               state_d = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (!strobe_s) state_d = IDLE;
         end
      endcase
   end

   assign bus.wr_ack = (state_q == WAIT_LOW);

   always_ff @(posedge clock) begin
      if (reset)      pattern <= '0;
      else if (wr_en) pattern[bus.wr_addr] <= bus.wr_data;
   end

   // Scan: digit_idx steps 3,2,1,0 once per DIGIT_CYCLES
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_cnt <= '0;
         digit_idx <= 2'd3;
      end else if (cycle_cnt == CNT_LAST) begin
         cycle_cnt <= '0;
         digit_idx <= digit_idx - 2'd1;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

   always_comb begin
      dig_n = 4'b1111;
      seg   = 8'h00;
      if (cycle_cnt >= BLANK_END) begin
         dig_n[digit_idx] = 1'b0;
         seg              = pattern[digit_idx];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) display <= pin_map(4'b1111, 8'h00);
      else       display <= pin_map(dig_n, seg);
   end

endmodule
